// File: rtl/if_id_hazard_ctrl.sv
// Pipeline hazard control for PC, IF/ID and ID/EX; optional HAZ_STATS_EN adds stall/flush counters.
// Latency: Mealy outputs respond in the detect cycle; stalls/flushes last the configured cycle counts.
// Backpressure: a stall holds PC and IF/ID; hazard inputs are ignored while a stall/flush sequence runs.
module if_id_hazard_ctrl #(
   parameter int REG_AW       = 4,
   parameter int BR_FLUSH_CYC = 2,
   parameter int LU_STALL_CYC = 1,
   parameter int MC_CYCLES    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs_a,
   input  logic [REG_AW-1:0] id_rs_b,
   input  logic              id_uses_b,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_rd,
   input  logic              ex_br_taken,
   input  logic              ex_mc_start,
   output logic              pc_wr_en,
   output logic              ifid_wr_en,
   output logic              ifid_flush_n,
   output logic              idex_wr_en,
   output logic              idex_nop_n,
   output logic [1:0]        ctrl_state
`ifdef HAZ_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_stall_cnt,
   output logic [15:0]       stat_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LU    = 2'd1,
      ST_FLUSH = 2'd2,
      ST_MC    = 2'd3
   } state_t;

   localparam logic [3:0] BR_LOAD = 4'(BR_FLUSH_CYC - 1);
   localparam logic [3:0] LU_LOAD = 4'(LU_STALL_CYC - 1);
   localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu_hit, br_evt;
   logic       pc_c, ifid_c, flush_c, idex_c, nop_c;

   assign lu_hit = ex_mem_rd && (ex_rd != '0) &&
                   ((ex_rd == id_rs_a) || (id_uses_b && (ex_rd == id_rs_b)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      br_evt    = 1'b0;
      pc_c      = 1'b1;
      ifid_c    = 1'b1;
      flush_c   = 1'b1;
      idex_c    = 1'b1;
      nop_c     = 1'b1;
      case (state)
         ST_RUN: begin
            if (ex_br_taken) begin
               br_evt  = 1'b1;
               flush_c = 1'b0;
               nop_c   = 1'b0;
               if (BR_FLUSH_CYC > 1) begin
                  state_nxt = ST_FLUSH;
                  cnt_nxt   = BR_LOAD;
               end
            end else if (ex_mc_start) begin
               pc_c      = 1'b0;
               ifid_c    = 1'b0;
               idex_c    = 1'b0;
               state_nxt = ST_MC;
               cnt_nxt   = MC_LOAD;
            end else if (lu_hit) begin
               pc_c   = 1'b0;
               ifid_c = 1'b0;
               nop_c  = 1'b0;
               if (LU_STALL_CYC > 1) begin
                  state_nxt = ST_LU;
                  cnt_nxt   = LU_LOAD;
               end
            end
         end
         ST_FLUSH: begin
            flush_c = 1'b0;
            nop_c   = 1'b0;
         end
         ST_MC: begin
            pc_c   = 1'b0;
            ifid_c = 1'b0;
            idex_c = 1'b0;
         end
         default: begin
            pc_c   = 1'b0;
            ifid_c = 1'b0;
            nop_c  = 1'b0;
         end
      endcase
      // Shared countdown for all non-RUN states; a stray zero count exits instead of wrapping.
      if (state != ST_RUN) begin
         cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
         if (cnt <= 4'd1) state_nxt = ST_RUN;
      end
   end

   assign pc_wr_en     = rst & pc_c;
   assign ifid_wr_en   = rst & ifid_c;
   assign ifid_flush_n = rst & flush_c;
   assign idex_wr_en   = rst & idex_c;
   assign idex_nop_n   = rst & nop_c;
   assign ctrl_state   = state;

`ifdef HAZ_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_stall_cnt <= '0;
         stat_flush_cnt <= '0;
      end else if (stat_clr) begin
         stat_stall_cnt <= '0;
         stat_flush_cnt <= '0;
      end else begin
         if (!pc_wr_en && (stat_stall_cnt != 16'hFFFF))
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
         if (br_evt && (stat_flush_cnt != 16'hFFFF))
            stat_flush_cnt <= stat_flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Randomized + directed bench for if_id_hazard_ctrl; two instances with different stall/flush lengths.
module tb_if_id_hazard_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] id_rs_a, id_rs_b, ex_rd;
   logic       id_uses_b, ex_mem_rd, ex_br_taken, ex_mc_start;
   logic       pc0, ifid0, fl0, idex0, nop0;
   logic       pc1, ifid1, fl1, idex1, nop1;
   logic [1:0] st0, st1;
`ifdef HAZ_STATS_EN
   logic        stat_clr;
   logic [15:0] sc0, fc0, sc1, fc1;
   int          m_sc0, m_fc0, m_sc1, m_fc1;
`endif

   if_id_hazard_ctrl #(.REG_AW(4), .BR_FLUSH_CYC(2), .LU_STALL_CYC(1), .MC_CYCLES(4)) dut0 (
      .clk(clk), .rst(rst), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_uses_b(id_uses_b),
      .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start),
      .pc_wr_en(pc0), .ifid_wr_en(ifid0), .ifid_flush_n(fl0), .idex_wr_en(idex0),
      .idex_nop_n(nop0), .ctrl_state(st0)
`ifdef HAZ_STATS_EN
      , .stat_clr(stat_clr), .stat_stall_cnt(sc0), .stat_flush_cnt(fc0)
`endif
   );

   if_id_hazard_ctrl #(.REG_AW(4), .BR_FLUSH_CYC(3), .LU_STALL_CYC(2), .MC_CYCLES(2)) dut1 (
      .clk(clk), .rst(rst), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_uses_b(id_uses_b),
      .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start),
      .pc_wr_en(pc1), .ifid_wr_en(ifid1), .ifid_flush_n(fl1), .idex_wr_en(idex1),
      .idex_nop_n(nop1), .ctrl_state(st1)
`ifdef HAZ_STATS_EN
      , .stat_clr(stat_clr), .stat_stall_cnt(sc1), .stat_flush_cnt(fc1)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: remaining busy cycles and the kind of event occupying them.
   // Kind codes match the visible ctrl_state values: 1 load-use, 2 branch flush, 3 multi-cycle.
   int left0, kind0, left1, kind1;

   function automatic int event_kind();
      bit hit;
      hit = ex_mem_rd && (ex_rd != 0) &&
            ((ex_rd == id_rs_a) || (id_uses_b && (ex_rd == id_rs_b)));
      if (ex_br_taken) return 2;
      if (ex_mc_start) return 3;
      if (hit)         return 1;
      return 0;
   endfunction

   // {pc_wr_en, ifid_wr_en, ifid_flush_n, idex_wr_en, idex_nop_n}
   function automatic logic [4:0] ctl_for(input int kind);
      case (kind)
         1:       return 5'b00110;
         2:       return 5'b11010;
         3:       return 5'b00101;
         default: return 5'b11111;
      endcase
   endfunction

   function automatic logic [6:0] expect_v(input int left, input int kind);
      if (!rst) return 7'd0;
      if (left > 0) return {ctl_for(kind), 2'(kind)};
      return {ctl_for(event_kind()), 2'b00};
   endfunction

   task automatic adv(inout int left, inout int kind, input int br_c, input int lu_c, input int mc_c);
      int k;
      if (left > 0) begin
         left--;
      end else begin
         k = event_kind();
         if (k != 0) begin
            kind = k;
            left = (k == 2) ? br_c - 1 : ((k == 3) ? mc_c - 1 : lu_c - 1);
         end
      end
   endtask

   function automatic logic [6:0] v0();
      return {pc0, ifid0, fl0, idex0, nop0, st0};
   endfunction
   function automatic logic [6:0] v1();
      return {pc1, ifid1, fl1, idex1, nop1, st1};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         left0 = 0; kind0 = 0; left1 = 0; kind1 = 0;
`ifdef HAZ_STATS_EN
         m_sc0 = 0; m_fc0 = 0; m_sc1 = 0; m_fc1 = 0;
`endif
      end else begin
`ifdef HAZ_STATS_EN
         if (stat_clr) begin
            m_sc0 = 0; m_fc0 = 0; m_sc1 = 0; m_fc1 = 0;
         end else begin
            if (!expect_v(left0, kind0)[6] && m_sc0 < 65535) m_sc0++;
            if (!expect_v(left1, kind1)[6] && m_sc1 < 65535) m_sc1++;
            if (left0 == 0 && event_kind() == 2 && m_fc0 < 65535) m_fc0++;
            if (left1 == 0 && event_kind() == 2 && m_fc1 < 65535) m_fc1++;
         end
`endif
         adv(left0, kind0, 2, 1, 4);
         adv(left1, kind1, 3, 2, 2);
      end
   end

   always @(negedge clk) begin
      chk("dut0_model", 32'(v0()), 32'(expect_v(left0, kind0)));
      chk("dut1_model", 32'(v1()), 32'(expect_v(left1, kind1)));
`ifdef HAZ_STATS_EN
      chk("dut0_stall_cnt", 32'(sc0), 32'(m_sc0));
      chk("dut0_flush_cnt", 32'(fc0), 32'(m_fc0));
      chk("dut1_stall_cnt", 32'(sc1), 32'(m_sc1));
      chk("dut1_flush_cnt", 32'(fc1), 32'(m_fc1));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs_a = 4'd0; id_rs_b = 4'd0; id_uses_b = 1'b0; ex_rd = 4'd0;
      ex_mem_rd = 1'b0; ex_br_taken = 1'b0; ex_mc_start = 1'b0;
   endtask

   task automatic set_lu();
      idle();
      ex_mem_rd = 1'b1; ex_rd = 4'd3; id_rs_a = 4'd3;
   endtask

   task automatic rand_in();
      id_rs_a     = 4'($urandom_range(0, 3));
      id_rs_b     = 4'($urandom_range(0, 3));
      ex_rd       = 4'($urandom_range(0, 3));
      id_uses_b   = 1'($urandom_range(0, 1));
      ex_mem_rd   = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 9) == 0);
      ex_mc_start = ($urandom_range(0, 11) == 0);
   endtask

   initial begin
      rst = 1'b0;
      rand_in();
`ifdef HAZ_STATS_EN
      stat_clr = 1'b0;
`endif
      // Reset held with random inputs: all outputs forced low.
      repeat (3) begin
         tick(); rand_in();
         @(negedge clk);
         chk("reset_outs_d0", 32'(v0()), 32'd0);
      end
      tick(); idle(); rst = 1'b1;
      @(negedge clk); chk("run_after_reset", 32'(v0()), 32'h7C);

      // Load-use: one bubble on dut0, two on dut1.
      tick(); set_lu();
      @(negedge clk); chk("lu_d0", 32'(v0()), 32'h18); chk("lu_d1_c1", 32'(v1()), 32'h18);
      tick(); idle();
      @(negedge clk); chk("lu_d0_done", 32'(v0()), 32'h7C); chk("lu_d1_c2", 32'(v1()), 32'h19);
      tick();
      @(negedge clk); chk("lu_d1_done", 32'(v1()), 32'h7C);

      // r0 destination never stalls.
      tick(); idle(); ex_mem_rd = 1'b1;
      @(negedge clk); chk("lu_r0_none", 32'(v0()), 32'h7C);

      // rs_b match only counts when rs_b is used.
      tick(); idle(); ex_mem_rd = 1'b1; ex_rd = 4'd5; id_rs_a = 4'd2; id_rs_b = 4'd5;
      @(negedge clk); chk("lu_rsb_unused", 32'(v0()), 32'h7C);
      tick(); id_uses_b = 1'b1;
      @(negedge clk); chk("lu_rsb_used", 32'(v0()), 32'h18);
      tick(); idle(); tick();

      // Branch: flush for two cycles on dut0, state 0 -> 2 -> 0.
      tick(); ex_br_taken = 1'b1;
      @(negedge clk); chk("br_detect", 32'(v0()), 32'h68);
      tick(); idle();
      @(negedge clk); chk("br_flush", 32'(v0()), 32'h6A);
      tick();
      @(negedge clk); chk("br_done", 32'(v0()), 32'h7C);
      tick();

      // Multi-cycle: 4 frozen cycles; load-use during MC ignored.
      tick(); ex_mc_start = 1'b1;
      @(negedge clk); chk("mc_c1", 32'(v0()), 32'h14);
      for (int i = 2; i <= 4; i++) begin
         tick(); set_lu();
         @(negedge clk); chk("mc_busy", 32'(v0()), 32'h17);
      end
      tick(); idle();
      @(negedge clk); chk("mc_done", 32'(v0()), 32'h7C);
      tick(); tick();

      // Simultaneous events: branch wins.
      tick(); set_lu(); ex_br_taken = 1'b1; ex_mc_start = 1'b1;
      @(negedge clk); chk("prio_br", 32'(v0()), 32'h68); chk("prio_br_d1", 32'(v1()), 32'h68);
      tick(); idle();
      @(negedge clk); chk("prio_flush", 32'(v0()), 32'h6A);
      tick(); tick(); tick();

      // Async reset in MC cycle 2.
      ex_mc_start = 1'b1;
      tick(); idle();
      #2 rst = 1'b0;
      #1 chk("rst_mid_mc", 32'(v0()), 32'd0);
      tick(); tick(); rst = 1'b1;
      @(negedge clk); chk("run_after_mc_rst", 32'(v0()), 32'h7C);

`ifdef HAZ_STATS_EN
      tick(); stat_clr = 1'b1;
      tick(); stat_clr = 1'b0;
      repeat (3) begin
         tick(); set_lu();
         tick(); idle();
         tick();
      end
      repeat (2) begin
         tick(); ex_br_taken = 1'b1;
         tick(); idle();
         tick(); tick();
      end
      @(negedge clk); chk("stat_stall_3", 32'(sc0), 32'd3); chk("stat_flush_2", 32'(fc0), 32'd2);
      tick(); stat_clr = 1'b1;
      tick(); stat_clr = 1'b0;
      @(negedge clk); chk("stat_clr_stall", 32'(sc0), 32'd0); chk("stat_clr_flush", 32'(fc0), 32'd0);
`endif

      // Randomized phase, with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         tick();
         rand_in();
`ifdef HAZ_STATS_EN
         stat_clr = ($urandom_range(0, 63) == 0);
`endif
         if ($urandom_range(0, 199) == 0) rst = 1'b0;
         else if (!rst && $urandom_range(0, 2) == 0) rst = 1'b1;
      end
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
